// File: rtl/rv_fetch_pkg.sv
// Shared types for the fetch/PC unit: FSM states, redirect selection and the NOP word.
package rv_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JAL  = 2'd2,
        SEL_JALR = 2'd3
    } redirect_sel_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jalr > jal > branch > pc+4) with redirect alignment check.
module next_pc_sel
    import rv_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jal,
    input  logic [31:0] jal_target,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    redirect_sel_e sel;

    always_comb begin
        if (jalr)              sel = SEL_JALR;
        else if (jal)          sel = SEL_JAL;
        else if (branch_taken) sel = SEL_BR;
        else                   sel = SEL_SEQ;
    end

    always_comb begin
        unique case (sel)
            SEL_JALR: next_pc = {jalr_target[31:1], 1'b0};
            SEL_JAL:  next_pc = jal_target;
            SEL_BR:   next_pc = branch_target;
            default:  next_pc = pc + 32'd4;
        endcase
    end

    // Sequential pc+4 from an aligned pc can never fault, so only redirects are checked.
    assign misaligned = (sel != SEL_SEQ) && (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch over a req/gnt/rvalid interface.
module fetch_pc_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jal,
    input  logic [31:0] jal_target,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        misalign_err,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         mis_q, mis_d;
    logic [31:0]  instr_q, instr_pc_q;
    logic         load_instr;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_sel u_next_pc_sel (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jal           (jal),
        .jal_target    (jal_target),
        .jalr          (jalr),
        .jalr_target   (jalr_target),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        mis_d      = 1'b0;
        load_instr = 1'b0;

        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        load_instr = 1'b1;
                        state_d    = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                if (!stall) begin
                    if (misaligned) begin
                        mis_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Flush overrides everything above; a granted or pending response must be discarded.
        if (flush) begin
            pc_d       = word_align(flush_pc);
            mis_d      = 1'b0;
            load_instr = 1'b0;
            unique case (state_q)
                ST_REQ: begin
                    state_d = imem_gnt ? ST_WAIT : ST_REQ;
                    kill_d  = imem_gnt;
                end
                ST_WAIT: begin
                    state_d = imem_rvalid ? ST_REQ : ST_WAIT;
                    kill_d  = !imem_rvalid;
                end
                default: begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            mis_q      <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            mis_q   <= mis_d;
            if (load_instr) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_q;
            end
        end
    end

    assign imem_req       = (state_q == ST_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == ST_VALID);
    assign instr          = instr_valid ? instr_q : NOP_INSTR;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + 32'd4;
    assign misalign_err   = mis_q;
    assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vectors, corner sequences, randomized run vs. a transaction-level model.
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jal;
    logic [31:0] jal_target;
    logic        jalr;
    logic [31:0] jalr_target;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        misalign_err;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jal            (jal),
        .jal_target     (jal_target),
        .jalr           (jalr),
        .jalr_target    (jalr_target),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .misalign_err   (misalign_err),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic [31:0] br_t;
        logic        jl;
        logic [31:0] jl_t;
        logic        jr;
        logic [31:0] jr_t;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch_taken  = 1'b0;
        branch_target = '0;
        jal           = 1'b0;
        jal_target    = '0;
        jalr          = 1'b0;
        jalr_target   = '0;
        stall         = 1'b0;
        flush         = 1'b0;
        flush_pc      = '0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check1({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_instr"}, instr, NOP);
        check({tag, "_instr_pc"}, instr_pc, 32'h0);
        check1({tag, "_mis"}, misalign_err, 1'b0);
        check1({tag, "_halted"}, halted, 1'b0);
    endtask

    // Redirect via flush, then serve one fetch with gnt immediately and rvalid a cycle later.
    task automatic fetch_at(input logic [31:0] pc);
        int n;
        flush    = 1'b1;
        flush_pc = pc;
        step();
        flush = 1'b0;
        n = 0;
        while (!imem_req && n < 10) begin
            step();
            n++;
        end
        check1("fetch_req", imem_req, 1'b1);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pc);
        step();
        imem_rvalid = 1'b0;
        check1("fetch_valid", instr_valid, 1'b1);
        check("fetch_instr", instr, mem_word(pc));
    endtask

    logic [31:0] exp_pc, prev_instr, tgt, raddr;
    logic        exp_halted, exp_mis, prev_valid, pend, redirect;
    int          rcnt, idle, deliveries;

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("rst");
        step();
        step();
        rst_n = 1'b1;

        // First fetch after reset release: one dead IDLE cycle, then REQ/WAIT/VALID.
        check1("idle_req", imem_req, 1'b0);
        step();
        check1("lat_req", imem_req, 1'b1);
        check("lat_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check1("lat_wait_req", imem_req, 1'b0);
        check1("lat_wait_valid", instr_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        check1("lat_valid", instr_valid, 1'b1);
        check("lat_instr", instr, 32'h0050_0093);
        check("lat_instr_pc", instr_pc, 32'h0);
        check("lat_plus4", instr_pc_plus4, 32'h4);
        step();
        check1("lat_next_req", imem_req, 1'b1);
        check("lat_next_addr", imem_addr, 32'h4);
        check({"lat_nop"}, instr, NOP);

        // Consume-cycle redirect vectors.
        vecs[0] = '{32'h0000_0040, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0000_0080, 1'b0};
        vecs[1] = '{32'h0000_0040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h105, 32'h0000_0104, 1'b0};
        vecs[2] = '{32'h0000_0104, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0104, 1'b1};
        vecs[3] = '{32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0014, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0000_0200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0300, 1'b0};
        vecs[6] = '{32'h0000_0300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h107, 32'h0000_0300, 1'b1};
        vecs[7] = '{32'h0000_0400, 1'b1, 32'h700, 1'b1, 32'h600, 1'b1, 32'h500, 32'h0000_0500, 1'b0};
        vecs[8] = '{32'h0000_0400, 1'b0, 32'h0, 1'b1, 32'h82, 1'b1, 32'h90, 32'h0000_0090, 1'b0};
        vecs[9] = '{32'h0000_0800, 1'b1, 32'h0, 1'b1, 32'h83, 1'b0, 32'h0, 32'h0000_0800, 1'b1};

        for (int i = 0; i < 10; i++) begin
            fetch_at(vecs[i].pc);
            check("vec_instr_pc", instr_pc, vecs[i].pc);
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].br_t;
            jal           = vecs[i].jl;
            jal_target    = vecs[i].jl_t;
            jalr          = vecs[i].jr;
            jalr_target   = vecs[i].jr_t;
            step();
            clear_inputs();
            check("vec_addr", imem_addr, vecs[i].exp_addr);
            check1("vec_mis", misalign_err, vecs[i].exp_mis);
            check1("vec_halted", halted, vecs[i].exp_mis);
            check1("vec_req", imem_req, !vecs[i].exp_mis);
            if (vecs[i].exp_mis) begin
                step();
                check1("vec_mis_pulse_end", misalign_err, 1'b0);
                check1("vec_halt_hold", halted, 1'b1);
                check1("vec_halt_req", imem_req, 1'b0);
            end
        end

        // Stall holds the presented instruction.
        fetch_at(32'h10);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check1("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, mem_word(32'h10));
            check("stall_instr_pc", instr_pc, 32'h10);
            check1("stall_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        step();
        check1("stall_rel_req", imem_req, 1'b1);
        check("stall_rel_addr", imem_addr, 32'h14);

        // Flush while waiting: the late response must be discarded.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h203;
        step();
        flush = 1'b0;
        check("wflush_addr", imem_addr, 32'h200);
        check1("wflush_req", imem_req, 1'b0);
        check1("wflush_valid", instr_valid, 1'b0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        step();
        imem_rvalid = 1'b0;
        check1("wflush_drop_valid", instr_valid, 1'b0);
        check1("wflush_refetch_req", imem_req, 1'b1);
        check("wflush_refetch_addr", imem_addr, 32'h200);
        step();
        check1("wflush_still_invalid", instr_valid, 1'b0);

        // Reset mid-WAIT, then a stale rvalid after release must be ignored.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        step();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        step();
        imem_rvalid = 1'b0;
        check1("stale_valid", instr_valid, 1'b0);
        check1("stale_req", imem_req, 1'b1);
        check("stale_addr", imem_addr, 32'h0);

        // Randomized run: DUT is in REQ at pc 0 with nothing outstanding.
        exp_pc     = 32'h0;
        exp_halted = 1'b0;
        exp_mis    = 1'b0;
        prev_valid = 1'b0;
        prev_instr = NOP;
        pend       = 1'b0;
        rcnt       = 0;
        raddr      = '0;
        idle       = 0;
        deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_addr", imem_addr, exp_pc);
            check1("rnd_mis", misalign_err, exp_mis);
            check1("rnd_halted", halted, exp_halted);
            if (exp_halted) begin
                check1("rnd_halt_req", imem_req, 1'b0);
                check1("rnd_halt_valid", instr_valid, 1'b0);
            end
            if (instr_valid) begin
                if (!prev_valid) begin
                    check("rnd_instr_pc", instr_pc, exp_pc);
                    check("rnd_instr", instr, mem_word(exp_pc));
                    deliveries++;
                end else begin
                    check("rnd_stable", instr, prev_instr);
                end
                check("rnd_plus4", instr_pc_plus4, exp_pc + 32'd4);
                idle = 0;
            end else begin
                check("rnd_nop", instr, NOP);
                if (exp_halted) idle = 0;
                else idle++;
            end
            if (idle > 60) begin
                check("rnd_progress", 32'(idle), 32'd0);
                break;
            end
            prev_valid = instr_valid;
            prev_instr = instr;

            // Memory responder: one outstanding request, response 1..3 cycles after gnt.
            imem_gnt    = ($urandom % 2) == 0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) begin
                if (rcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(raddr);
                    pend        = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (imem_req && imem_gnt) begin
                pend  = 1'b1;
                rcnt  = $urandom % 3;
                raddr = imem_addr;
            end

            stall         = ($urandom % 10) < 3;
            branch_taken  = ($urandom % 4) == 0;
            jal           = ($urandom % 7) == 0;
            jalr          = ($urandom % 7) == 0;
            branch_target = {$urandom} & (($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jal_target    = {$urandom} & (($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jalr_target   = {$urandom} & (($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD);
            flush         = exp_halted ? (($urandom % 4) == 0) : (($urandom % 40) == 0);
            flush_pc      = $urandom;

            // Reference model: what the next edge does to the architectural PC.
            exp_mis = 1'b0;
            if (flush) begin
                exp_pc     = flush_pc & 32'hFFFF_FFFC;
                exp_halted = 1'b0;
            end else if (instr_valid && !stall) begin
                redirect = 1'b1;
                if (jalr)              tgt = jalr_target & 32'hFFFF_FFFE;
                else if (jal)          tgt = jal_target;
                else if (branch_taken) tgt = branch_target;
                else begin
                    tgt      = exp_pc + 32'd4;
                    redirect = 1'b0;
                end
                if (redirect && (tgt % 4 != 0)) begin
                    exp_mis    = 1'b1;
                    exp_halted = 1'b1;
                end else begin
                    exp_pc = tgt;
                end
            end
            step();
        end
        clear_inputs();
        check1("rnd_deliveries", deliveries > 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
